vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Samples VGA_HS, VGA_VS and VGA_BLANK on the pixel clock. Recovers pixel coordinates (X, Y), data enable, and line/frame start strobes.
- Checks that every frame has exactly HDISP x VDISP active pixels and reports lock and errors.
- Used by pixel consumers (framebuffer writer, pattern checker) downstream of any VGA-timed source.

Parameters:
- HDISP, 640, active pixels per line expected.
- VDISP, 480, active lines per frame expected.
- LOCK_FRAMES, 2, consecutive good frames required before LOCKED asserts (range 1..15).

Ports:
- CLK  in  1  pixel clock; all logic on posedge.
- RST  in  1  asynchronous active-low reset; all state cleared while low.
- VGA_HS  in  1  horizontal sync, active low.
- VGA_VS  in  1  vertical sync, active low.
- VGA_BLANK  in  1  high during active pixels.
- DE  out  1  registered data enable; high when X/Y address a valid active pixel.
- X  out  $clog2(HDISP)  active pixel column.
- Y  out  $clog2(VDISP)  active line row.
- LINE_START  out  1  one-cycle pulse with the first active pixel of each line.
- FRAME_START  out  1  one-cycle pulse with pixel (0,0) of a frame.
- LOCKED  out  1  geometry verified for LOCK_FRAMES consecutive frames.
- ERR  out  1  one-cycle pulse when a frame fails the geometry check.

Behaviour:
- Reset (RST low):
  - DE=0, X=0, Y=0, LINE_START=0, FRAME_START=0, LOCKED=0, ERR=0.
  - Input registers load HS=1, VS=1, BLANK=0.
  - FSM enters SEARCH; good-frame counter is 0.
- Input stage: one register on each of HS/VS/BLANK. Edges are detected against the previous registered value.
- Latency: output signals reflect the input sample from 2 cycles earlier. BLANK high at cycle n gives DE high at cycle n+2.
- Frame boundary: falling edge of registered VS. Line start: rising edge of registered BLANK. Line end: falling edge of registered BLANK.
- Counters:
  - pixel counter: 0 at each BLANK rise, +1 per active cycle.
  - line counter: 0 at VS fall, +1 at each BLANK fall.
  - Both are one bit wider than X/Y and saturate at all-ones; no wrap.
- Outputs: X/Y are the low bits of the counters. DE = BLANK_reg AND FSM in ACTIVE AND pixel counter < HDISP AND line counter < VDISP.
- FSM states:
  - SEARCH: ignore everything until a VS fall -> ARMED.
  - ARMED: wait for the first BLANK rise -> ACTIVE. FRAME_START and LINE_START pulse with that first pixel.
  - ACTIVE: on each BLANK fall, compare the pixel count with HDISP. A mismatch sets the frame-bad flag. On the next VS fall -> CHECK.
  - CHECK (one cycle):
    - Frame is good if the bad flag is clear and the line count == VDISP.
    - Good frame: increment the good-frame counter (saturating at LOCK_FRAMES); LOCKED=1 once it equals LOCK_FRAMES.
    - Bad frame: ERR pulses, counter cleared, LOCKED=0.
    - Then -> ARMED. The VS fall that caused CHECK counts as the frame boundary, so line counting for the new frame starts there.
- LINE_START pulses on every BLANK rise in ACTIVE/ARMED. FRAME_START pulses only on the first BLANK rise after a VS fall.
- Simultaneous events:
  - VS fall in the same cycle as BLANK fall: line end is processed first, then the frame check.
  - BLANK high while VS is low: counts as a line; the frame fails at CHECK if VDISP is exceeded.
- BLANK never rising within a frame: line count 0 -> frame bad.
- Counter saturation: DE stays 0 beyond HDISP/VDISP; the frame is flagged bad.
- Reset mid-frame: immediate return to the reset state. Lock must be re-acquired starting from SEARCH.

Optional Feature:
- Macro: VGA_SYNC_DECODER_MEAS_EN.
- When defined, two extra outputs exist:
  - MEAS_HTOTAL (16 bits): clocks between the last two HS falling edges.
  - MEAS_VTOTAL (16 bits): HS falls between the last two VS falling edges.
- Both are reset to 0, update in the cycle after the closing edge, and saturate at 16'hFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Nominal 640x480 stream (HFP 16, HPULSE 96, HBP 48, VFP 11, VPULSE 2, VBP 31) for 4 frames:
  - LOCKED rises at CHECK of frame 2.
  - DE high 640x480 cycles per frame; ERR never pulses.
- Coordinates:
  - first active pixel -> X=0, Y=0 with FRAME_START=1, 2 cycles after BLANK rise.
  - last active pixel -> X=639, Y=479.
- After lock, one line with 641 active pixels: ERR pulses once at that frame's CHECK, LOCKED falls, and it re-asserts after 2 good frames.
- Frame with 479 active lines: ERR pulse and LOCKED=0; DE still asserts for lines 0..478.
- Assert RST low mid-line at X=300: all outputs are 0 the same cycle, and DE stays 0 until the next VS fall plus BLANK rise.
- With VGA_SYNC_DECODER_MEAS_EN defined, nominal stream: MEAS_HTOTAL=800 and MEAS_VTOTAL=524 after the second frame.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers X/Y, DE and line/frame strobes and verifies frame geometry.
// Define VGA_SYNC_DECODER_MEAS_EN to add the MEAS_HTOTAL/MEAS_VTOTAL measurement outputs.
module vga_sync_decoder #(
  parameter int unsigned HDISP       = 640,
  parameter int unsigned VDISP       = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     VGA_HS,
  input  logic                     VGA_VS,
  input  logic                     VGA_BLANK,
  output logic                     DE,
  output logic [$clog2(HDISP)-1:0] X,
  output logic [$clog2(VDISP)-1:0] Y,
  output logic                     LINE_START,
  output logic                     FRAME_START,
  output logic                     LOCKED,
  output logic                     ERR
`ifdef VGA_SYNC_DECODER_MEAS_EN
  ,
  output logic [15:0]              MEAS_HTOTAL,
  output logic [15:0]              MEAS_VTOTAL
`endif
);

  localparam int unsigned XW = $clog2(HDISP);
  localparam int unsigned YW = $clog2(VDISP);
  localparam int unsigned PW = XW + 1;
  localparam int unsigned LW = YW + 1;

  typedef enum logic [1:0] {SEARCH, ARMED, ACTIVE, CHECK} state_e;

  logic hs_q, vs_q, blank_q, hs_prev_q, vs_prev_q, blank_prev_q;
  logic vs_fall, b_rise, b_fall, hs_fall, start, h_bad, bad_n;

  state_e        state_q, state_d;
  logic [PW-1:0] pix_q, pix_d, pix_idx;
  logic [LW-1:0] line_q, line_d, line_cnt;
  logic          bad_q, bad_d, good_q, good_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic          de_q, de_d, ls_q, ls_d, fs_q, fs_d, locked_q, locked_d, err_q, err_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    vs_fall  = vs_prev_q & ~vs_q;
    hs_fall  = hs_prev_q & ~hs_q;
    b_rise   = blank_q & ~blank_prev_q;
    b_fall   = ~blank_q & blank_prev_q;

    // pix_q is the number of active pixels seen so far in the line, i.e. the index of the next one
    pix_idx  = b_rise ? '0 : pix_q;
    pix_d    = pix_q;
    if (blank_q) pix_d = (pix_idx == '1) ? pix_idx : pix_idx + 1'b1;

    // the line ending on this cycle is counted before any coincident frame boundary
    line_cnt = (b_fall && line_q != '1) ? line_q + 1'b1 : line_q;
    line_d   = vs_fall ? '0 : line_cnt;

    h_bad    = b_fall && (pix_q != PW'(HDISP));
    bad_n    = bad_q | h_bad;
    start    = b_rise && (state_q == ARMED || state_q == CHECK);

    de_d     = blank_q && (state_q == ACTIVE || start) &&
               (pix_idx < PW'(HDISP)) && (line_q < LW'(VDISP));
    x_d      = pix_idx[XW-1:0];
    y_d      = line_q[YW-1:0];
    ls_d     = b_rise && (state_q != SEARCH);
    fs_d     = start;

    state_d  = state_q;
    bad_d    = bad_q;
    good_d   = good_q;
    gcnt_d   = gcnt_q;
    locked_d = locked_q;
    err_d    = 1'b0;

    case (state_q)
      SEARCH: if (vs_fall) state_d = ARMED;
      ARMED: begin
        if (b_rise) begin
          state_d = ACTIVE;
          bad_d   = 1'b0;
        end else if (vs_fall) begin
          state_d = CHECK;
          good_d  = 1'b0;
        end
      end
      ACTIVE: begin
        bad_d = bad_n;
        if (vs_fall) begin
          state_d = CHECK;
          good_d  = !bad_n && (line_cnt == LW'(VDISP));
        end
      end
      CHECK: begin
        if (good_q) begin
          if (gcnt_q != 4'(LOCK_FRAMES)) gcnt_d = gcnt_q + 1'b1;
          locked_d = (gcnt_d == 4'(LOCK_FRAMES));
        end else begin
          err_d    = 1'b1;
          gcnt_d   = '0;
          locked_d = 1'b0;
        end
        bad_d   = 1'b0;
        state_d = b_rise ? ACTIVE : ARMED;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blank_q      <= 1'b0;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      blank_prev_q <= 1'b0;
      state_q      <= SEARCH;
      pix_q        <= '0;
      line_q       <= '0;
      bad_q        <= 1'b0;
      good_q       <= 1'b0;
      gcnt_q       <= '0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      ls_q         <= 1'b0;
      fs_q         <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hs_q         <= VGA_HS;
      vs_q         <= VGA_VS;
      blank_q      <= VGA_BLANK;
      hs_prev_q    <= hs_q;
      vs_prev_q    <= vs_q;
      blank_prev_q <= blank_q;
      state_q      <= state_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      bad_q        <= bad_d;
      good_q       <= good_d;
      gcnt_q       <= gcnt_d;
      de_q         <= de_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ls_q         <= ls_d;
      fs_q         <= fs_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign DE          = de_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;
  assign LOCKED      = locked_q;
  assign ERR         = err_q;

`ifdef VGA_SYNC_DECODER_MEAS_EN
  logic [15:0] hcnt_q, hcnt_d, htot_q, htot_d, vcnt_q, vcnt_d, vtot_q, vtot_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // hcnt restarts at 1 on the HS fall so it reads the full period at the next fall
  always_comb begin
    hcnt_d   = sat_inc(hcnt_q);
    htot_d   = htot_q;
    h_seen_d = h_seen_q;
    if (hs_fall) begin
      if (h_seen_q) htot_d = hcnt_q;
      hcnt_d   = 16'd1;
      h_seen_d = 1'b1;
    end
    vcnt_d   = hs_fall ? sat_inc(vcnt_q) : vcnt_q;
    vtot_d   = vtot_q;
    v_seen_d = v_seen_q;
    if (vs_fall) begin
      if (v_seen_q) vtot_d = vcnt_d;
      vcnt_d   = '0;
      v_seen_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hcnt_q   <= '0;
      htot_q   <= '0;
      h_seen_q <= 1'b0;
      vcnt_q   <= '0;
      vtot_q   <= '0;
      v_seen_q <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      htot_q   <= htot_d;
      h_seen_q <= h_seen_d;
      vcnt_q   <= vcnt_d;
      vtot_q   <= vtot_d;
      v_seen_q <= v_seen_d;
    end
  end

  assign MEAS_HTOTAL = htot_q;
  assign MEAS_VTOTAL = vtot_q;
`else
  logic hs_unused;
  assign hs_unused = hs_fall;
`endif

endmodule
